// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor, carry chain split into STAGES registered segments.
// Optional saturation on signed overflow is enabled with the ADDSUB_SAT_EN macro (adds the SAT port).
module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             CTRL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef ADDSUB_SAT_EN
    input  logic             SAT,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO,
    output logic             NEG
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Handshake: a beat moves across an interface on a rising edge where valid and ready are both 1;
    // the whole pipe advances together (adv), so a stalled output freezes every stage, bubbles included.
    logic              adv;
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
`ifdef ADDSUB_SAT_EN
    logic [STAGES-1:0] sat_q, sat_d;
    logic              sat_in;
`endif

    logic [WIDTH-1:0]  a_in, b_in, s_in;
    logic              c_in, v_in;
    logic [SEG:0]      seg_sum;

    assign adv      = OUT_READY | ~v_q[LAST];
    assign IN_READY = adv & ~RST;

    // Stage k adds segment k of whatever the previous register holds; stage 0 takes the ports.
    always_comb begin
        a_in    = A;
        b_in    = B ^ {WIDTH{CTRL}};
        c_in    = CTRL;
        s_in    = '0;
        v_in    = IN_VALID & IN_READY;
        seg_sum = '0;
        v_d     = '0;
        c_d     = '0;
`ifdef ADDSUB_SAT_EN
        sat_in  = SAT;
        sat_d   = '0;
`endif
        for (int k = 0; k < STAGES; k++) begin
            seg_sum = {1'b0, a_in[k*SEG +: SEG]} + {1'b0, b_in[k*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_in};
            s_in[k*SEG +: SEG] = seg_sum[SEG-1:0];
            a_d[k] = a_in;
            b_d[k] = b_in;
            s_d[k] = s_in;
            c_d[k] = seg_sum[SEG];
            v_d[k] = v_in;
`ifdef ADDSUB_SAT_EN
            sat_d[k] = sat_in;
            sat_in   = sat_q[k];
`endif
            a_in = a_q[k];
            b_in = b_q[k];
            s_in = s_q[k];
            c_in = c_q[k];
            v_in = v_q[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q <= '0;
            c_q <= '0;
`ifdef ADDSUB_SAT_EN
            sat_q <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (adv) begin
            v_q <= v_d;
            c_q <= c_d;
`ifdef ADDSUB_SAT_EN
            sat_q <= sat_d;
`endif
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= s_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

    logic [WIDTH-1:0] s_raw;
    logic             a_msb, b_msb;

    assign s_raw     = s_q[LAST];
    assign a_msb     = a_q[LAST][WIDTH-1];
    assign b_msb     = b_q[LAST][WIDTH-1];
    assign OUT_VALID = v_q[LAST];
    assign COUT      = c_q[LAST];
    assign OVF       = (a_msb == b_msb) & (s_raw[WIDTH-1] != a_msb);
    // Gated by valid so an empty pipe reports ZERO = 0 rather than describing the cleared sum.
    assign ZERO      = v_q[LAST] & ~|s_raw;
    assign NEG       = s_raw[WIDTH-1];

`ifdef ADDSUB_SAT_EN
    assign S = (sat_q[LAST] & OVF)
             ? (a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
             : s_raw;
`else
    assign S = s_raw;
`endif

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor for the 16-bit RISC datapath. It is the successor to the combinational 16-bit full adder/subtractor. The carry chain is split into `STAGES` registered segments, so long widths close timing. Operands enter through a valid/ready handshake, and results leave through one with carry, signed-overflow, zero and negative flags. It sits between the register-file read ports and the writeback mux, and the ALU and address-generation paths can share it.

## Interface
- `WIDTH`, 16, operand/result width in bits; must be ≥ 2 and an integer multiple of `STAGES`.
- `STAGES`, 2, number of carry-chain segments; each segment ends in a register; legal range 1..`WIDTH`.

Ports:
- `CLK`  in  1  rising-edge clock; the only clock.
- `RST`  in  1  synchronous, active-high reset.
- `IN_VALID`  in  1  operand beat valid.
- `IN_READY`  out  1  block can accept an operand beat this cycle.
- `CTRL`  in  1  0 = A+B, 1 = A−B; sampled with the operands.
- `A`  in  `WIDTH`  operand A.
- `B`  in  `WIDTH`  operand B.
- `OUT_VALID`  out  1  result beat valid.
- `OUT_READY`  in  1  consumer accepts the result beat.
- `S`  out  `WIDTH`  sum/difference, modulo 2^`WIDTH`.
- `COUT`  out  1  carry out of the MSB.
  - On subtract it is the raw carry of A + ~B + 1: 1 = no borrow, i.e. A ≥ B unsigned.
- `OVF`  out  1  signed overflow.
- `ZERO`  out  1  S == 0.
- `NEG`  out  1  S[`WIDTH`−1].
- `SAT`  in  1  saturate on signed overflow. Present only under `ADDSUB_SAT_EN`.

## Operation
- Subtract is computed as A + (B XOR {`WIDTH`{CTRL}}) + CTRL, with CTRL as carry-in to segment 0.
- Segment width is SEG = `WIDTH`/`STAGES`.
- Stage k (k = 1..`STAGES`) register holds:
  - sum bits for segments 0..k−1;
  - the carry out of segment k−1;
  - the still-unprocessed upper operand bits (B already conditionally inverted);
  - the sign bits A[MSB] and B'[MSB] needed for `OVF`;
  - `SAT` (when present);
  - a valid bit.
- Global advance: ADV = OUT_READY | ~OUT_VALID. All stage registers load only when ADV = 1. When ADV = 0, every stage holds, including empty stages; bubbles are not compressed.
- IN_READY = ADV & ~RST. A beat is accepted on a rising edge with IN_VALID & IN_READY. Stage-1 valid loads IN_VALID & IN_READY whenever ADV = 1.
- Flags come from the last stage:
  - `OVF` = (A[MSB] == B'[MSB]) & (S[MSB] != A[MSB]);
  - `ZERO` = (S == 0);
  - `NEG` = S[MSB].
- `COUT`, `OVF`, `ZERO` and `NEG` describe the unsaturated result, even when saturation fires.
- Results leave in strict acceptance order. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge t appears on `OUT_VALID`/`S`/flags after edge t+`STAGES−1`, i.e. it is visible in the cycle following that edge. With `STAGES` = 1 it is visible in the cycle after acceptance.
- Throughput: one beat per cycle while OUT_READY = 1.
- While OUT_VALID & ~OUT_READY, all outputs are held stable and IN_READY = 0.
- Simultaneous output handoff and input accept in one cycle is legal and lossless.
- Reset: on any edge with RST = 1, all valid bits clear. `OUT_VALID`, `S`, `COUT`, `OVF`, `ZERO` and `NEG` go to 0. IN_READY is 0 while RST = 1 and is 1 in the first cycle after RST falls.
- Reset mid-operation discards in-flight beats; nothing emerges afterwards.
- Wrap-around: FFFF+0001 gives S = 0000 with COUT = 1; no trap.

## Configuration
- `ADDSUB_SAT_EN` defined:
  - The `SAT` port exists and is carried through the pipe with its beat.
  - If SAT = 1 and OVF = 1, S is clamped: to 0x7FF…F when A[MSB] = 0, else to 0x800…0. The flags still reflect the unsaturated result.
- `ADDSUB_SAT_EN` undefined: no `SAT` port, no clamp logic, and S always wraps.

## Test plan
- Add with `WIDTH`=16, `STAGES`=2, CTRL=0: A=0005, B=0003 accepted at edge t → at t+1, OUT_VALID=1, S=0008, COUT=0, OVF=0, ZERO=0, NEG=0.
- Subtract with CTRL=1:
  - A=0008, B=0003 → S=0005, COUT=1.
  - A=0003, B=0005 → S=FFFE, COUT=0, NEG=1, OVF=0.
- Wrap and overflow with CTRL=0:
  - A=FFFF, B=0001 → S=0000, COUT=1, ZERO=1.
  - A=7FFF, B=7FFF → S=FFFE, OVF=1, NEG=1.
- Saturation with CTRL=1, A=8000, B=7FFF → OVF=1, and:
  - with `ADDSUB_SAT_EN` and SAT=1: S=8000;
  - with SAT=0 or without the macro: S=0001.
- Backpressure: stream 6 beats back-to-back and hold OUT_READY=0 for 3 cycles mid-stream → IN_READY=0 during the stall, outputs stable, all 6 results in order with none lost.
- Reset mid-stream: assert RST for 1 cycle with 2 beats in flight → OUT_VALID=0 and all outputs 0 next cycle, no stale beat emerges, IN_READY=1 the cycle after RST falls.
